// File: rtl/activation_loader.sv
// activation_loader: gathers four 8-bit activation words (row-major a11, a12,
// a21, a22) into a 2x2 matrix, presents it with valid for HOLD_CYCLES cycles,
// then pulses done for one cycle before returning to LOAD.
`timescale 1ns/1ps
module activation_loader #(
  parameter int HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] a11,
  output logic [7:0] a12,
  output logic [7:0] a21,
  output logic [7:0] a22,
  output logic       valid,
  output logic       done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  // Hold counter start value; the feed window length is fixed at build time.
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  state_t     state_r;
  logic [1:0] word_cnt_r;
  logic [3:0] hold_cnt_r;

  // Ready is a pure decode of the state so upstream sees it in the same cycle.
  always_comb begin
    if (state_r == LOAD) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  // Main controller: word steering, feed window timing and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LOAD;
      word_cnt_r <= 2'd0;
      hold_cnt_r <= 4'd0;
      a11        <= 8'h00;
      a12        <= 8'h00;
      a21        <= 8'h00;
      a22        <= 8'h00;
      valid      <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      // Abort wins over everything, including a word offered this cycle.
      state_r    <= LOAD;
      word_cnt_r <= 2'd0;
      hold_cnt_r <= 4'd0;
      a11        <= 8'h00;
      a12        <= 8'h00;
      a21        <= 8'h00;
      a22        <= 8'h00;
      valid      <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          done <= 1'b0;
          if (in_valid) begin
            case (word_cnt_r)
              2'd0:    a11 <= in_data;
              2'd1:    a12 <= in_data;
              2'd2:    a21 <= in_data;
              2'd3:    a22 <= in_data;
              default: a11 <= in_data;
            endcase
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              // Matrix complete: open the feed window from the next cycle.
              state_r    <= FEED;
              hold_cnt_r <= HOLD_INIT;
              valid      <= 1'b1;
            end else begin
              valid <= 1'b0;
            end
          end else begin
            valid <= 1'b0;
          end
        end
        FEED: begin
          // hold_cnt_r holds the number of valid cycles still to present,
          // including the current one.
          if (hold_cnt_r <= 4'd1) begin
            state_r    <= DONE;
            hold_cnt_r <= 4'd0;
            valid      <= 1'b0;
            done       <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
            valid      <= 1'b1;
            done       <= 1'b0;
          end
        end
        DONE: begin
          state_r <= LOAD;
          valid   <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r    <= LOAD;
          word_cnt_r <= 2'd0;
          hold_cnt_r <= 4'd0;
          valid      <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_loader.sv
// Testbench for activation_loader: a default build (HOLD_CYCLES=3) and a
// HOLD_CYCLES=1 build share stimulus; each is predicted by a timeline model
// (words collected so far, cycles elapsed since the matrix completed).
`timescale 1ns/1ps
module tb_activation_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       r0, v0, dn0;
  logic [7:0] p11, p12, p21, p22;
  logic       r1, v1, dn1;
  logic [7:0] q11, q12, q21, q22;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance.
  int         m_nw   [2];
  int         m_t    [2];
  int         m_hold [2];
  logic [7:0] m_mat  [2][4];

  activation_loader #(.HOLD_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r0), .a11(p11), .a12(p12), .a21(p21), .a22(p22), .valid(v0), .done(dn0)
  );

  activation_loader #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r1), .a11(q11), .a12(q12), .a21(q21), .a22(q22), .valid(v1), .done(dn1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_mat(input int i, input int k);
    logic [7:0] r;
    case ({i[0], k[1:0]})
      3'b000: r = p11;
      3'b001: r = p12;
      3'b010: r = p21;
      3'b011: r = p22;
      3'b100: r = q11;
      3'b101: r = q12;
      3'b110: r = q21;
      default: r = q22;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] dut_flags(input int i);
    return (i == 0) ? {r0, v0, dn0} : {r1, v1, dn1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_nw[i] = 0;
      m_t[i]  = 0;
      for (int k = 0; k < 4; k++) m_mat[i][k] = 8'h00;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_nw[i] = 0;
        m_t[i]  = 0;
        for (int k = 0; k < 4; k++) m_mat[i][k] = 8'h00;
      end else if (m_t[i] == 0) begin
        if (in_valid) begin
          m_mat[i][m_nw[i]] = in_data;
          m_nw[i] = m_nw[i] + 1;
          if (m_nw[i] == 4) begin
            m_nw[i] = 0;
            m_t[i]  = 1;
          end
        end
      end else begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] > m_hold[i] + 1) m_t[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    clear    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({r0, v0, dn0} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags got %b want %b", {r0, v0, dn0}, 3'b100);
    end
    n_checks++;
    if ({p11, p12, p21, p22} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_matrix got %h want %h", {p11, p12, p21, p22}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] want;
    do_reset();
    send_word(8'd1);
    n_checks++;
    if (p11 !== 8'd1) begin
      n_fail++;
      $display("FAIL first_word_after_reset got %0d want %0d", p11, 1);
    end
    send_word(8'd2);
    send_word(8'd3);
    send_word(8'd4);
    n_checks++;
    if ({p11, p12, p21, p22} !== {8'd1, 8'd2, 8'd3, 8'd4}) begin
      n_fail++;
      $display("FAIL basic_matrix got %h want %h", {p11, p12, p21, p22}, {8'd1, 8'd2, 8'd3, 8'd4});
    end
    for (int c = 0; c < 5; c++) begin
      // {in_ready, valid, done}: three valid cycles, one done cycle, then LOAD.
      want = (c < 3) ? 3'b010 : ((c == 3) ? 3'b001 : 3'b100);
      n_checks++;
      if ({r0, v0, dn0} !== want) begin
        n_fail++;
        $display("FAIL basic_window c=%0d got %b want %b", c, {r0, v0, dn0}, want);
      end
      step();
    end
  endtask

  task automatic test_gaps_and_feed_block();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      send_word(8'd5 + 8'(w));
      if (w < 3) begin
        for (int g = 0; g < 2; g++) begin
          n_checks++;
          if (v0 !== 1'b0 || r0 !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_early_valid w=%0d got v=%b r=%b want v=0 r=1", w, v0, r0);
          end
          step();
        end
      end
    end
    n_checks++;
    if ({p11, p12, p21, p22, v0} !== {8'd5, 8'd6, 8'd7, 8'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL gap_matrix got %h v=%b want 05060708 v=1", {p11, p12, p21, p22}, v0);
    end
    // Offer word 9 throughout the feed window; it must wait for LOAD.
    in_valid = 1'b1;
    in_data  = 8'd9;
    n_checks++;
    if (r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL feed_ready got %b want 0", r0);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (p11 !== 8'd5 || r0 !== 1'b0) begin
        n_fail++;
        $display("FAIL feed_blocked c=%0d got a11=%0d r=%b want a11=5 r=0", c, p11, r0);
      end
    end
    step();
    n_checks++;
    if (r0 !== 1'b1 || p11 !== 8'd5) begin
      n_fail++;
      $display("FAIL load_resume got r=%b a11=%0d want r=1 a11=5", r0, p11);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (p11 !== 8'd9 || p12 !== 8'd6) begin
      n_fail++;
      $display("FAIL held_word got a11=%0d a12=%0d want 9 6", p11, p12);
    end
  endtask

  task automatic test_clear_load();
    do_reset();
    send_word(8'h21);
    send_word(8'h22);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({p11, p12, p21, p22, v0, dn0, r0} !== {32'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL clear_load got %h v=%b d=%b r=%b want 0 v=0 d=0 r=1",
               {p11, p12, p21, p22}, v0, dn0, r0);
    end
    for (int w = 0; w < 4; w++) send_word(8'd10 + 8'(w));
    n_checks++;
    if ({p11, p12, p21, p22, v0} !== {8'd10, 8'd11, 8'd12, 8'd13, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_reload got %h v=%b want 0a0b0c0d v=1", {p11, p12, p21, p22}, v0);
    end
  endtask

  task automatic test_abort_feed();
    do_reset();
    for (int w = 0; w < 4; w++) send_word(8'h30 + 8'(w));
    step();
    n_checks++;
    if (v0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_second_feed got v=%b want 1", v0);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if ({v0, dn0, r0} !== 3'b001 || {p11, p12, p21, p22} !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_feed got v=%b d=%b r=%b m=%h want v=0 d=0 r=1 m=0",
               v0, dn0, r0, {p11, p12, p21, p22});
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (dn0 !== 1'b0 || v0 !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_no_done c=%0d got d=%b v=%b want 0 0", c, dn0, v0);
      end
    end
    for (int w = 0; w < 4; w++) send_word(8'h40 + 8'(w));
    step();
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({v0, dn0, r0} !== 3'b001 || {p11, p12, p21, p22} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_feed got v=%b d=%b r=%b m=%h want v=0 d=0 r=1 m=0",
               v0, dn0, r0, {p11, p12, p21, p22});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (dn0 !== 1'b0 || v0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done c=%0d got d=%b v=%b want 0 0", c, dn0, v0);
      end
    end
  endtask

  task automatic test_back_to_back_hold1();
    int   idx;
    logic acc;
    logic [2:0] want;
    do_reset();
    idx      = 0;
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int k = 1; k <= 12; k++) begin
      acc = r1;
      step();
      if (acc && idx < 8) begin
        idx++;
        in_data = 8'h11 + 8'(idx);
        if (idx == 8) in_valid = 1'b0;
      end
      want = {!(k == 4 || k == 5 || k == 10 || k == 11), (k == 4 || k == 10), (k == 5 || k == 11)};
      n_checks++;
      if ({r1, v1, dn1} !== want) begin
        n_fail++;
        $display("FAIL hold1_window k=%0d got %b want %b", k, {r1, v1, dn1}, want);
      end
      if (k == 4) begin
        n_checks++;
        if ({q11, q12, q21, q22} !== 32'h11121314) begin
          n_fail++;
          $display("FAIL hold1_matrix1 got %h want %h", {q11, q12, q21, q22}, 32'h11121314);
        end
      end else if (k == 10) begin
        n_checks++;
        if ({q11, q12, q21, q22} !== 32'h15161718) begin
          n_fail++;
          $display("FAIL hold1_matrix2 got %h want %h", {q11, q12, q21, q22}, 32'h15161718);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] want;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = 8'($urandom);
      clear    = ($urandom_range(0, 99) < 4);
      step();
      for (int i = 0; i < 2; i++) begin
        want = {m_t[i] == 0, (m_t[i] >= 1) && (m_t[i] <= m_hold[i]), m_t[i] == m_hold[i] + 1};
        n_checks++;
        if (dut_flags(i) !== want) begin
          n_fail++;
          $display("FAIL rand_flags inst=%0d c=%0d got %b want %b", i, c, dut_flags(i), want);
        end
        for (int k = 0; k < 4; k++) begin
          n_checks++;
          if (dut_mat(i, k) !== m_mat[i][k]) begin
            n_fail++;
            $display("FAIL rand_matrix inst=%0d c=%0d k=%0d got %h want %h",
                     i, c, k, dut_mat(i, k), m_mat[i][k]);
          end
        end
      end
    end
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    m_hold[0] = 3;
    m_hold[1] = 1;
    model_reset();
    test_reset();
    test_basic();
    test_gaps_and_feed_block();
    test_clear_load();
    test_abort_feed();
    test_back_to_back_hold1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
